systolic_result_reader: RTL and testbench

- Host-side drain engine for the systolic NPU.
- After the controller has written result matrix C to the shared data memory, this block reads the n×n words starting at `addr_C` and streams them out over a valid/ready interface with a last-beat flag.
- It is the read-back counterpart of the controller's result write path and shares the same single-port memory (falling-edge clocked, 12-bit address, WIDTH-bit data) through a request/grant pair.

---
 rtl/systolic_result_reader_pkg.sv | 24 ++
 rtl/systolic_result_reader_skid_fifo.sv | 63 ++++++
 rtl/systolic_result_reader.sv | 164 ++++++++++++++++
 tb/tb_systolic_result_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_result_reader_pkg.sv
// Shared types for the result drain engine: reader FSM encoding, skid FIFO depth,
// and the matrix element offset helper used for address generation.
package systolic_result_reader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_GNT,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } reader_state_t;

   localparam int READER_FIFO_DEPTH = 2;

   // major*dim + minor; the 4-bit dimension keeps this within 8 bits
   function automatic logic [7:0] elem_offset(input logic [3:0] dim,
                                               input logic [3:0] major,
                                               input logic [3:0] minor);
      logic [7:0] prod;
      prod = {4'd0, major} * {4'd0, dim};
      return prod + {4'd0, minor};
   endfunction

endpackage

// File: rtl/systolic_result_reader_skid_fifo.sv
// Two-entry FIFO holding read words plus their last-beat flag; zero-latency head view.
// Pushes while full and pops while empty are dropped; the reader never issues either.
module result_skid_fifo
   import systolic_result_reader_pkg::*;
#(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] pop_dat,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);

   logic [W-1:0] slot_q [2];
   logic [W-1:0] slot_d [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push, do_pop;

   assign full    = (count_q == 2'(READER_FIFO_DEPTH));
   assign empty   = (count_q == 2'd0);
   assign count   = count_q;
   assign pop_dat = slot_q[rd_ptr_q];

   always_comb begin
      slot_d   = slot_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      do_push  = push && !full;
      do_pop   = pop && !empty;
      if (do_push) begin
         slot_d[wr_ptr_q] = push_dat;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(do_push) - 2'(do_pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            slot_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         slot_q   <= slot_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/systolic_result_reader.sv
// Drains the n x n result matrix from shared memory onto a valid/ready stream; first beat 2 cycles after grant.
// Address issue stalls on lost grant or a full FIFO; READER_TRANSPOSE_EN switches to column-major (C transposed).
module systolic_result_reader
   import systolic_result_reader_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr_C,
   input  logic [3:0]        n,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [WIDTH-1:0]  mem_q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   reader_state_t     state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [3:0]        dim_q, dim_d;
   logic [3:0]        outer_q, outer_d;
   logic [3:0]        inner_q, inner_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              rd_vld_q, rd_vld_d;
   logic              rd_last_q, rd_last_d;
   logic              done_q, done_d;

   logic [WIDTH:0]    fifo_head;
   logic              fifo_full, fifo_empty, fifo_vld;
   logic [1:0]        fifo_count;
   logic              beat_pop;
   logic [2:0]        occ_after;
   logic              room;
   logic              issue;
   logic [3:0]        dim_m1;
   logic              at_last;
   logic [7:0]        elem_off;
   logic [ADDR_W-1:0] cur_addr;

   result_skid_fifo #(.W(WIDTH + 1)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (rd_vld_q),
      .push_dat ({rd_last_q, mem_q}),
      .pop      (beat_pop),
      .pop_dat  (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   assign fifo_vld = !fifo_empty;
   assign beat_pop = fifo_vld && out_ready;

   // Occupancy once this edge's in-flight word lands and any accepted beat leaves
   assign occ_after = {1'b0, fifo_count} + {2'b0, rd_vld_q} - {2'b0, beat_pop};
   assign room      = !(fifo_full && !beat_pop) && (occ_after < 3'(READER_FIFO_DEPTH));

   assign dim_m1  = dim_q - 4'd1;
   assign at_last = (outer_q == dim_m1) && (inner_q == dim_m1);

`ifdef READER_TRANSPOSE_EN
   assign elem_off = elem_offset(dim_q, inner_q, outer_q);
`else
   assign elem_off = elem_offset(dim_q, outer_q, inner_q);
`endif

   assign cur_addr = base_q + ADDR_W'(elem_off);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         dim_q      <= 4'd0;
         outer_q    <= 4'd0;
         inner_q    <= 4'd0;
         mem_addr_q <= '0;
         rd_vld_q   <= 1'b0;
         rd_last_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         dim_q      <= dim_d;
         outer_q    <= outer_d;
         inner_q    <= inner_d;
         mem_addr_q <= mem_addr_d;
         rd_vld_q   <= rd_vld_d;
         rd_last_q  <= rd_last_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      dim_d      = dim_q;
      outer_d    = outer_q;
      inner_d    = inner_q;
      mem_addr_d = mem_addr_q;
      rd_vld_d   = 1'b0;
      rd_last_d  = rd_last_q;
      done_d     = (state_q == ST_DONE);
      issue      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d  = addr_C;
               dim_d   = n;
               outer_d = 4'd0;
               inner_d = 4'd0;
               state_d = (n == 4'd0) ? ST_DONE : ST_WAIT_GNT;
            end
         end
         ST_WAIT_GNT: issue = mem_gnt && room;
         ST_READ:     issue = mem_gnt && room;
         ST_DRAIN: begin
            if (beat_pop && fifo_head[WIDTH]) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // The issued word is captured at the next edge whether or not grant holds
      if (issue) begin
         mem_addr_d = cur_addr;
         rd_vld_d   = 1'b1;
         rd_last_d  = at_last;
         if (at_last) begin
            state_d = ST_DRAIN;
         end else begin
            state_d = ST_READ;
            if (inner_q == dim_m1) begin
               inner_d = 4'd0;
               outer_d = outer_q + 4'd1;
            end else begin
               inner_d = inner_q + 4'd1;
            end
         end
      end
   end

   always_comb begin
      mem_req   = (state_q == ST_WAIT_GNT) || (state_q == ST_READ);
      busy      = (state_q != ST_IDLE);
      done      = done_q;
      mem_addr  = mem_addr_q;
      out_valid = fifo_vld;
      out_data  = fifo_head[WIDTH-1:0];
      out_last  = fifo_head[WIDTH] && fifo_vld;
   end

endmodule

// File: tb/tb_systolic_result_reader.sv
// Directed bench for systolic_result_reader; memory model returns (address - 0x108) for every word.
module tb_systolic_result_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] addr_C;
   logic [3:0]  n;
   logic        mem_req;
   logic        mem_gnt;
   logic [11:0] mem_addr;
   logic [15:0] mem_q;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;

   int checks = 0;
   int fails  = 0;

   systolic_result_reader #(.WIDTH(16), .ADDR_W(12)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .addr_C    (addr_C),
      .n         (n),
      .mem_req   (mem_req),
      .mem_gnt   (mem_gnt),
      .mem_addr  (mem_addr),
      .mem_q     (mem_q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Falling-edge memory: word at address a holds a - 0x108
   always @(negedge clk) mem_q = 16'(mem_addr) - 16'h0108;

   logic [15:0] beat_dat [$];
   bit          beat_last [$];
   int          beat_cyc [$];
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_cyc = -1;
   int          req_cnt = 0;
   int          stab_err = 0;
   bit          hold_vld = 1'b0;
   logic [16:0] hold_val = '0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (hold_vld && rst && (!out_valid || {out_last, out_data} !== hold_val)) stab_err = stab_err + 1;
      hold_vld = out_valid && !out_ready;
      hold_val = {out_last, out_data};
      if (out_valid && out_ready) begin
         beat_dat.push_back(out_data);
         beat_last.push_back(out_last);
         beat_cyc.push_back(cyc);
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (mem_req) req_cnt = req_cnt + 1;
   end

   // Stream position k of an n x n drain -> row-major element index
   function automatic int exp_idx(input int k, input int dim);
`ifdef READER_TRANSPOSE_EN
      return (k % dim) * dim + (k / dim);
`else
      return k;
`endif
   endfunction

   task automatic do_start(input logic [11:0] a, input logic [3:0] nn);
      @(posedge clk); #1;
      start = 1'b1; addr_C = a; n = nn;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input int d0, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (done_cnt != d0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; addr_C = '0; n = '0; mem_gnt = 1'b1; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (mem_req !== 1'b0)    begin fails++; $display("FAIL reset_mem_req got %0h want 0", mem_req); end
      checks++; if (mem_addr !== 12'h0)  begin fails++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
      checks++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
      checks++; if (out_data !== 16'h0)  begin fails++; $display("FAIL reset_out_data got %0h want 0", out_data); end
      checks++; if (out_last !== 1'b0)   begin fails++; $display("FAIL reset_out_last got %0h want 0", out_last); end
      checks++; if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy got %0h want 0", busy); end
      checks++; if (done !== 1'b0)       begin fails++; $display("FAIL reset_done got %0h want 0", done); end
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_basic();
      int b0 = beat_dat.size();
      int d0 = done_cnt;
      bit ok;
      logic [15:0] want;
      do_start(12'h100, 4'd4);
      @(negedge clk);
      checks++; if (busy !== 1'b1)      begin fails++; $display("FAIL basic_busy_edge0 got %0h want 1", busy); end
      checks++; if (mem_req !== 1'b1)   begin fails++; $display("FAIL basic_req_edge0 got %0h want 1", mem_req); end
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_edge0 got %0h want 0", out_valid); end
      @(negedge clk);
      checks++; if (mem_addr !== 12'h100) begin fails++; $display("FAIL basic_first_addr got %0h want 100", mem_addr); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1)    begin fails++; $display("FAIL basic_first_valid got %0h want 1", out_valid); end
      checks++; if (out_data !== 16'hFFF8) begin fails++; $display("FAIL basic_first_data got %0h want fff8", out_data); end
      // start while busy must not disturb the running drain
      @(posedge clk); #1 start = 1'b1; addr_C = 12'h700; n = 4'd2;
      @(posedge clk); #1 start = 1'b0;
      wait_done(200, d0, ok);
      checks++; if (!ok) begin fails++; $display("FAIL basic_done_timeout got none want pulse"); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done got %0h want 0", busy); end
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++; if (beat_dat.size() - b0 != 16) begin fails++; $display("FAIL basic_beat_count got %0d want 16", beat_dat.size() - b0); end
      checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); end
      if (beat_dat.size() - b0 >= 16) begin
         for (int i = 0; i < 16; i++) begin
            want = 16'(exp_idx(i, 4)) - 16'd8;
            checks++; if (beat_dat[b0+i] !== want) begin fails++; $display("FAIL basic_data[%0d] got %0h want %0h", i, beat_dat[b0+i], want); end
            checks++; if (beat_last[b0+i] !== (i == 15)) begin fails++; $display("FAIL basic_last[%0d] got %0b want %0b", i, beat_last[b0+i], (i == 15)); end
         end
         // handshake at the edge after negedge L; done rises one edge later, seen at negedge L+2
         checks++; if (done_cyc !== beat_cyc[b0+15] + 2) begin fails++; $display("FAIL basic_done_timing got %0d want %0d", done_cyc, beat_cyc[b0+15] + 2); end
      end
   endtask

   task automatic test_backpressure();
      int b0 = beat_dat.size();
      int d0 = done_cnt;
      int s0 = stab_err;
      bit ok = 1'b0;
      logic [15:0] want;
      do_start(12'h200, 4'd3);
      for (int c = 0; c < 300; c++) begin
         out_ready = (c % 3 == 0);
         @(posedge clk); #1;
         if (done_cnt != d0) begin ok = 1'b1; break; end
      end
      out_ready = 1'b1;
      checks++; if (!ok) begin fails++; $display("FAIL bp_done_timeout got none want pulse"); end
      checks++; if (beat_dat.size() - b0 != 9) begin fails++; $display("FAIL bp_beat_count got %0d want 9", beat_dat.size() - b0); end
      checks++; if (stab_err != s0) begin fails++; $display("FAIL bp_stall_stability got %0d changes want 0", stab_err - s0); end
      if (beat_dat.size() - b0 >= 9) begin
         for (int i = 0; i < 9; i++) begin
            want = 16'h00F8 + 16'(exp_idx(i, 3));
            checks++; if (beat_dat[b0+i] !== want) begin fails++; $display("FAIL bp_data[%0d] got %0h want %0h", i, beat_dat[b0+i], want); end
            checks++; if (beat_last[b0+i] !== (i == 8)) begin fails++; $display("FAIL bp_last[%0d] got %0b want %0b", i, beat_last[b0+i], (i == 8)); end
         end
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_gnt_stall();
      int b0 = beat_dat.size();
      int d0 = done_cnt;
      bit ok = 1'b0;
      logic [15:0] want;
      do_start(12'h100, 4'd4);
      for (int e = 1; e < 120; e++) begin
         @(posedge clk); #1;
         mem_gnt = !(e >= 6 && e <= 10);
         if (done_cnt != d0) begin ok = 1'b1; break; end
      end
      mem_gnt = 1'b1;
      checks++; if (!ok) begin fails++; $display("FAIL gnt_done_timeout got none want pulse"); end
      checks++; if (beat_dat.size() - b0 != 16) begin fails++; $display("FAIL gnt_beat_count got %0d want 16", beat_dat.size() - b0); end
      if (beat_dat.size() - b0 >= 16) begin
         for (int i = 0; i < 16; i++) begin
            want = 16'(exp_idx(i, 4)) - 16'd8;
            checks++; if (beat_dat[b0+i] !== want) begin fails++; $display("FAIL gnt_data[%0d] got %0h want %0h", i, beat_dat[b0+i], want); end
         end
         checks++; if (beat_cyc[b0+6] - beat_cyc[b0+5] < 5) begin fails++; $display("FAIL gnt_stall_gap got %0d want >=5", beat_cyc[b0+6] - beat_cyc[b0+5]); end
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_wrap();
      int b0 = beat_dat.size();
      int d0 = done_cnt;
      bit ok;
      logic [15:0] tbl [4];
      tbl[0] = 16'h0EF6; tbl[1] = 16'h0EF7; tbl[2] = 16'hFEF8; tbl[3] = 16'hFEF9;
      do_start(12'hFFE, 4'd2);
      wait_done(100, d0, ok);
      checks++; if (!ok) begin fails++; $display("FAIL wrap_done_timeout got none want pulse"); end
      checks++; if (beat_dat.size() - b0 != 4) begin fails++; $display("FAIL wrap_beat_count got %0d want 4", beat_dat.size() - b0); end
      if (beat_dat.size() - b0 >= 4) begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (beat_dat[b0+i] !== tbl[exp_idx(i, 2)]) begin fails++; $display("FAIL wrap_data[%0d] got %0h want %0h", i, beat_dat[b0+i], tbl[exp_idx(i, 2)]); end
         end
         checks++; if (beat_last[b0+3] !== 1'b1) begin fails++; $display("FAIL wrap_last got %0b want 1", beat_last[b0+3]); end
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_n0();
      int b0 = beat_dat.size();
      int r0 = req_cnt;
      do_start(12'h050, 4'd0);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL n0_busy got %0h want 1", busy); end
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL n0_done_early got %0h want 0", done); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL n0_busy_clear got %0h want 0", busy); end
      checks++; if (done !== 1'b1) begin fails++; $display("FAIL n0_done got %0h want 1", done); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL n0_done_pulse got %0h want 0", done); end
      checks++; if (req_cnt != r0) begin fails++; $display("FAIL n0_mem_req got %0d cycles want 0", req_cnt - r0); end
      checks++; if (beat_dat.size() != b0) begin fails++; $display("FAIL n0_beats got %0d want 0", beat_dat.size() - b0); end
   endtask

   task automatic test_reset_mid();
      int b0;
      int d0;
      bit ok;
      logic [15:0] tbl [4];
      tbl[0] = 16'h01F8; tbl[1] = 16'h01F9; tbl[2] = 16'h01FA; tbl[3] = 16'h01FB;
      do_start(12'h100, 4'd4);
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0)   begin fails++; $display("FAIL rmid_mem_req got %0h want 0", mem_req); end
      checks++; if (mem_addr !== 12'h0) begin fails++; $display("FAIL rmid_mem_addr got %0h want 0", mem_addr); end
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_out_valid got %0h want 0", out_valid); end
      checks++; if (out_data !== 16'h0) begin fails++; $display("FAIL rmid_out_data got %0h want 0", out_data); end
      checks++; if (out_last !== 1'b0)  begin fails++; $display("FAIL rmid_out_last got %0h want 0", out_last); end
      checks++; if (busy !== 1'b0)      begin fails++; $display("FAIL rmid_busy got %0h want 0", busy); end
      checks++; if (done !== 1'b0)      begin fails++; $display("FAIL rmid_done got %0h want 0", done); end
      d0 = done_cnt;
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      checks++; if (done_cnt != d0) begin fails++; $display("FAIL rmid_partial_done got %0d want 0", done_cnt - d0); end
      b0 = beat_dat.size();
      do_start(12'h300, 4'd2);
      wait_done(100, d0, ok);
      checks++; if (!ok) begin fails++; $display("FAIL rmid_done_timeout got none want pulse"); end
      checks++; if (beat_dat.size() - b0 != 4) begin fails++; $display("FAIL rmid_beat_count got %0d want 4", beat_dat.size() - b0); end
      if (beat_dat.size() - b0 >= 4) begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (beat_dat[b0+i] !== tbl[exp_idx(i, 2)]) begin fails++; $display("FAIL rmid_data[%0d] got %0h want %0h", i, beat_dat[b0+i], tbl[exp_idx(i, 2)]); end
         end
      end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_gnt_stall();
      test_wrap();
      test_n0();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
